// File: rtl/input_channel.sv
// Generic FWFT FIFO: registered storage, head visible the cycle after the write.
// Latency 1 cycle write-to-read, no bypass; full_o deasserts the writer's ready.
module sync_fifo #(
  parameter int W       = 10,
  parameter int DEPTH_W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         vld_o,
  output logic         full_o
);
  localparam int DEPTH = 1 << DEPTH_W;

  logic [W-1:0]       mem_q [DEPTH];
  logic [W-1:0]       mem_d [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o = (count_q == (DEPTH_W+1)'(DEPTH));
  assign vld_o  = (count_q != '0);
  assign dout_o = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push_ok  = push_i & ~full_o;
    pop_ok   = pop_i & vld_o;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{DEPTH_W{1'b0}}, push_ok} - {{DEPTH_W{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// Wormhole router input port: flit FIFO, XY route on head flits, packet-long one-hot request.
// Route latency 1 cycle after the head reaches the FIFO head; rdy_o drops when the FIFO is full.
module input_channel #(
  parameter int DATA_W      = 10,
  parameter int X_W         = 2,
  parameter int Y_W         = 2,
  parameter int ROUTER_X    = 0,
  parameter int ROUTER_Y    = 0,
  parameter int BUF_DEPTH_W = 2,
  parameter int OUT_N       = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic [OUT_N-1:0]  req_o,
  input  logic [OUT_N-1:0]  grant_i,
  input  logic [OUT_N-1:0]  oc_rdy_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_vld_o,
  output logic              flit_id_is_tail_o,
  output logic              err_o
);
  typedef enum logic {IDLE, BUSY} state_e;

  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

  state_e             state_q, state_d;
  logic [OUT_N-1:0]   route_q, route_d;
  logic [OUT_N-1:0]   route_calc;
  logic [DATA_W-1:0]  fifo_dat;
  logic               fifo_vld, fifo_full;
  logic               push, pop, xfer, err_pop;
  logic [1:0]         flit_id;
  logic [X_W-1:0]     dest_x;
  logic [Y_W-1:0]     dest_y;

  assign rdy_o = ~fifo_full;
  assign push  = vld_i & rdy_o;

  sync_fifo #(
    .W       (DATA_W),
    .DEPTH_W (BUF_DEPTH_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .din_i  (data_i),
    .pop_i  (pop),
    .dout_o (fifo_dat),
    .vld_o  (fifo_vld),
    .full_o (fifo_full)
  );

  // flit_id bit 0 marks a head, bit 1 marks a tail (2'b11 is both).
  assign flit_id           = fifo_dat[DATA_W-1:DATA_W-2];
  assign dest_x            = fifo_dat[X_W+Y_W-1:Y_W];
  assign dest_y            = fifo_dat[Y_W-1:0];
  assign data_vld_o        = fifo_vld;
  assign data_o            = fifo_vld ? fifo_dat : '0;
  assign flit_id_is_tail_o = fifo_vld & flit_id[1];

  always_comb begin
    route_calc = '0;
    if (dest_x > RX)      route_calc[P_EAST]  = 1'b1;
    else if (dest_x < RX) route_calc[P_WEST]  = 1'b1;
    else if (dest_y > RY) route_calc[P_NORTH] = 1'b1;
    else if (dest_y < RY) route_calc[P_SOUTH] = 1'b1;
    else                  route_calc[P_LOCAL] = 1'b1;
  end

  assign xfer = fifo_vld & |(req_o & grant_i & oc_rdy_i);
  assign pop  = xfer | err_pop;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    req_o   = '0;
    err_o   = 1'b0;
    err_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_vld) begin
          if (flit_id[0]) begin
            route_d = route_calc;
            state_d = BUSY;
          end else begin
            // Orphan body/tail with no open packet: drop it and flag.
            err_o   = 1'b1;
            err_pop = 1'b1;
          end
        end
      end
      BUSY: begin
        req_o = route_q;
        if (xfer && flit_id[1]) begin
          route_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end
endmodule
